tdpram_param: RTL and testbench

Parametrised true dual-port synchronous RAM that supersedes the fixed 24x4096 coefficient buffer in the keygen datapath. Each port has its own enable, selectable read-during-write behaviour and an optional output pipeline register. Same-address write collisions are detected and flagged. A built-in clear sequencer fills the whole array with a constant after reset, so polynomial buffers never expose stale secret coefficients.

---
 rtl/tdpram_param.sv | 91 +++++++++
 tb/tb_tdpram_param.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tdpram_param.sv
// tdpram_param: true dual-port RAM with per-port read-during-write mode, optional output register,
// same-address write collision flag and a post-reset clear sequencer.
module tdpram_param #(
    parameter int DATA_W = 24,
    parameter int DEPTH = 4096,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int RDW_MODE = 0,
    parameter int OUT_REG = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    input  logic              en_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] dout_a,
    input  logic              en_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b,
    output logic              collision
);
    localparam int K_W = ADDR_W > 1 ? ADDR_W - 1 : 1;
    typedef enum logic [1:0] {RESET, CLEAR, READY} state_t;
    state_t state_q, state_d;
    logic [K_W-1:0] k_q, k_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic ready, clr, last, acc_a, acc_b, wr_a, wr_b;
    logic [ADDR_W-1:0] wa_a, wa_b;
    logic [DATA_W-1:0] wd_a, wd_b;
    logic [DATA_W-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d, pd_a_q, pd_a_d, pd_b_q, pd_b_d;
    logic en1_a_q, en1_a_d, en1_b_q, en1_b_d, col_q, col_d;
    always_comb begin
        ready = state_q == READY;
        clr = state_q == CLEAR;
        last = k_q == K_W'(DEPTH / 2 - 1);
        state_d = state_q == RESET ? CLEAR : clr && last ? READY : state_q;
        k_d = clr ? k_q + K_W'(1) : '0;
        acc_a = ready && en_a;
        acc_b = ready && en_b;
        // the clear sequencer borrows both ports: even words on A, odd words on B
        wr_a = !rst && (clr || (acc_a && we_a));
        wr_b = !rst && (clr || (acc_b && we_b));
        wa_a = clr ? ADDR_W'({k_q, 1'b0}) : addr_a;
        wa_b = clr ? ADDR_W'({k_q, 1'b1}) : addr_b;
        wd_a = clr ? CLEAR_VAL : din_a;
        wd_b = clr ? CLEAR_VAL : din_b;
        rd_a_d = !ready ? '0 : en_a ? (we_a && RDW_MODE != 0 ? din_a : mem[addr_a]) : rd_a_q;
        rd_b_d = !ready ? '0 : en_b ? (we_b && RDW_MODE != 0 ? din_b : mem[addr_b]) : rd_b_q;
        en1_a_d = acc_a;
        en1_b_d = acc_b;
        pd_a_d = !ready ? '0 : en1_a_q ? rd_a_q : pd_a_q;
        pd_b_d = !ready ? '0 : en1_b_q ? rd_b_q : pd_b_q;
        col_d = acc_a && acc_b && we_a && we_b && addr_a == addr_b;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET;
            k_q <= '0;
            rd_a_q <= '0;
            rd_b_q <= '0;
            pd_a_q <= '0;
            pd_b_q <= '0;
            en1_a_q <= 1'b0;
            en1_b_q <= 1'b0;
            col_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q <= k_d;
            rd_a_q <= rd_a_d;
            rd_b_q <= rd_b_d;
            pd_a_q <= pd_a_d;
            pd_b_q <= pd_b_d;
            en1_a_q <= en1_a_d;
            en1_b_q <= en1_b_d;
            col_q <= col_d;
        end
    end
    // port A is written last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (wr_b) mem[wa_b] <= wd_b;
        if (wr_a) mem[wa_a] <= wd_a;
    end
    assign busy = !ready;
    assign collision = col_q;
    assign dout_a = OUT_REG != 0 ? pd_a_q : rd_a_q;
    assign dout_b = OUT_REG != 0 ? pd_b_q : rd_b_q;
endmodule

// File: tb/tb_tdpram_param.sv
// tb_tdpram_param: two DUT flavours (read-first/unregistered, write-first/registered) driven in lockstep
// and compared every cycle against an array-based reference model plus directed constant checks.
module tb_tdpram_param;
    localparam int DW = 24;
    localparam int D = 16;
    localparam int AW = 4;
    localparam logic [DW-1:0] CV = 24'hABCDEF;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] din_a = '0, din_b = '0;
    logic u0_busy, u1_busy, u0_col, u1_col;
    logic [DW-1:0] u0_da, u0_db, u1_da, u1_db;
    int checks = 0, passes = 0, fails = 0;
    logic [DW-1:0] mem [D];
    int clr_left = 0;
    logic [DW-1:0] e0a = '0, e0b = '0, s1a = '0, s1b = '0, e1a = '0, e1b = '0;
    logic ecol = 1'b0;

    tdpram_param #(.DATA_W(DW), .DEPTH(D), .RDW_MODE(0), .OUT_REG(0), .CLEAR_VAL(CV)) u0 (
        .clk(clk), .rst(rst), .busy(u0_busy),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(u0_da),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(u0_db),
        .collision(u0_col));
    tdpram_param #(.DATA_W(DW), .DEPTH(D), .RDW_MODE(1), .OUT_REG(1), .CLEAR_VAL(CV)) u1 (
        .clk(clk), .rst(rst), .busy(u1_busy),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(u1_da),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(u1_db),
        .collision(u1_col));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input logic en, input logic we, input int addr, input logic [DW-1:0] din);
        en_a = en; we_a = we; addr_a = AW'(addr); din_a = din;
    endtask

    task automatic set_b(input logic en, input logic we, input int addr, input logic [DW-1:0] din);
        en_b = en; we_b = we; addr_b = AW'(addr); din_b = din;
    endtask

    // one clock: advance the reference model from the current inputs, then compare every output
    task automatic cyc();
        logic ac_a, ac_b;
        logic [DW-1:0] oa, ob;
        ac_a = !rst && clr_left == 0 && en_a;
        ac_b = !rst && clr_left == 0 && en_b;
        oa = mem[addr_a];
        ob = mem[addr_b];
        if (rst) begin
            clr_left = D / 2 + 1;
            foreach (mem[i]) mem[i] = CV;
            e0a = '0; e0b = '0; s1a = '0; s1b = '0; e1a = '0; e1b = '0; ecol = 1'b0;
        end else begin
            ecol = ac_a && ac_b && we_a && we_b && addr_a == addr_b;
            e1a = s1a;
            e1b = s1b;
            if (ac_a) begin e0a = oa; s1a = we_a ? din_a : oa; end
            if (ac_b) begin e0b = ob; s1b = we_b ? din_b : ob; end
            if (ac_b && we_b) mem[addr_b] = din_b;
            if (ac_a && we_a) mem[addr_a] = din_a;
            if (clr_left > 0) clr_left--;
        end
        @(posedge clk);
        #1;
        chk("u0_busy", DW'(u0_busy), DW'(clr_left > 0));
        chk("u1_busy", DW'(u1_busy), DW'(clr_left > 0));
        chk("u0_collision", DW'(u0_col), DW'(ecol));
        chk("u1_collision", DW'(u1_col), DW'(ecol));
        chk("u0_dout_a", u0_da, e0a);
        chk("u0_dout_b", u0_db, e0b);
        chk("u1_dout_a", u1_da, e1a);
        chk("u1_dout_b", u1_db, e1b);
    endtask

    task automatic busy_len(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (u0_busy) n++;
            else break;
        end
        chk(tag, DW'(n), DW'(D / 2));
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < D; i++) begin
            set_a(1, 0, i, '0);
            set_b(1, 0, D - 1 - i, '0);
            cyc();
            chk(tag, u0_da, CV);
            chk(tag, u0_db, CV);
        end
        set_a(0, 0, 0, '0);
        set_b(0, 0, 0, '0);
        cyc();
    endtask

    initial begin
        cyc();
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 40 && clr_left > 0; i++) cyc();
        for (int i = 0; i < D / 2; i++) begin
            set_a(1, 1, i, DW'($urandom));
            set_b(1, 1, i + D / 2, DW'($urandom));
            cyc();
        end
        set_a(0, 0, 0, '0);
        set_b(0, 0, 0, '0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        busy_len("clear_busy_len");
        read_all("clear_read");

        set_a(1, 1, 5, 24'h000111);
        cyc();
        set_a(1, 1, 5, 24'h222333);
        cyc();
        chk("rdw_read_first", u0_da, 24'h000111);
        set_a(1, 0, 5, '0);
        cyc();
        chk("rdw_after_u0", u0_da, 24'h222333);
        chk("rdw_write_first_u1", u1_da, 24'h222333);
        set_a(0, 0, 0, '0);
        cyc();
        chk("rdw_after_u1", u1_da, 24'h222333);

        set_b(1, 1, 9, 24'h7FFFFF);
        cyc();
        set_a(1, 1, 9, 24'h000001);
        set_b(1, 0, 9, '0);
        cyc();
        chk("cross_old", u0_db, 24'h7FFFFF);
        set_a(0, 0, 0, '0);
        cyc();
        chk("cross_new", u0_db, 24'h000001);
        set_b(0, 0, 0, '0);

        set_a(1, 1, 3, 24'h123456);
        set_b(1, 1, 3, 24'h654321);
        cyc();
        chk("coll_pulse", DW'(u0_col), 1);
        set_a(1, 0, 3, '0);
        set_b(0, 0, 0, '0);
        cyc();
        chk("coll_one_cycle", DW'(u0_col), 0);
        chk("coll_a_wins", u0_da, 24'h123456);
        set_a(1, 1, 3, 24'h111111);
        set_b(1, 1, 4, 24'h222222);
        cyc();
        chk("coll_diff_addr", DW'(u1_col), 0);

        set_a(1, 1, 7, 24'h00ABCD);
        set_b(0, 0, 0, '0);
        cyc();
        set_a(1, 0, 5, '0);
        cyc();
        cyc();
        set_a(1, 0, 7, '0);
        cyc();
        chk("lat_not_yet", u1_da, 24'h222333);
        set_a(0, 0, 0, '0);
        cyc();
        chk("lat_two", u1_da, 24'h00ABCD);
        cyc();
        cyc();
        chk("lat_hold", u1_da, 24'h00ABCD);

        for (int i = 0; i < 400; i++) begin
            set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                  ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, D - 1), DW'($urandom));
            set_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                  ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, D - 1), DW'($urandom));
            cyc();
        end

        rst = 1'b1;
        cyc();
        chk("rst_op_dout", u0_da, '0);
        chk("rst_op_dout_u1", u1_db, '0);
        set_a(0, 0, 0, '0);
        set_b(0, 0, 0, '0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        rst = 1'b1;
        cyc();
        chk("rst_clr_dout", u0_da, '0);
        chk("rst_clr_col", DW'(u0_col), 0);
        rst = 1'b0;
        busy_len("midclear_busy_len");
        read_all("midclear_read");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
